// File: rtl/soc_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package soc_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        GAP,
        WR,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/soc_mem_lsu_if.sv
// Memory bus between the load/store unit (master) and the block RAM controller (slave).
// Byte order is big-endian: the byte at mem_addr travels in bits [31:24].
interface soc_mem_lsu_if #(
    parameter int addr_width = 8
);
    logic [addr_width-1:0] mem_addr;
    logic [31:0]           mem_dwrite;
    logic [31:0]           mem_dread;
    logic                  mem_rw;
    logic                  mem_valid;
    logic                  mem_ready;

    modport master (
        output mem_addr,
        output mem_dwrite,
        output mem_rw,
        output mem_valid,
        input  mem_dread,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_dwrite,
        input  mem_rw,
        input  mem_valid,
        output mem_dread,
        output mem_ready
    );
endinterface

// File: rtl/soc_lsu_align.sv
// Combinational lane logic: sub-word extract/extend for loads and the
// read-modify-write merge for stores. The addressed byte is always rdata[31:24].
module soc_lsu_align
    import soc_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    // Word accesses pass straight through; sub-word ones pick/replace the top lanes.
    always_comb begin
        load_data  = rdata;
        merge_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{sign_ext & rdata[31]}}, rdata[31:24]};
                merge_data = {wdata[7:0], rdata[23:0]};
            end
            SZ_HALF: begin
                load_data  = {{16{sign_ext & rdata[31]}}, rdata[31:16]};
                merge_data = {wdata[15:0], rdata[15:0]};
            end
            default: begin
                load_data  = rdata;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/soc_mem_lsu.sv
// Load/store unit: turns core byte/half/word requests into one or two bus
// transactions (sub-word stores are read-modify-write) with a ready timeout.
module soc_mem_lsu
    import soc_lsu_pkg::*;
#(
    parameter int addr_width     = 8,
    parameter int timeout_cycles = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [addr_width-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    soc_mem_lsu_if.master         mem
);

    localparam logic [15:0] TIMEOUT = 16'(timeout_cycles);

    lsu_state_t            state_reg;
    logic                  we_reg;
    logic                  signed_reg;
    logic [1:0]            size_reg;
    logic [31:0]           wdata_reg;
    logic                  err_pend_reg;
    logic [15:0]           timer_reg;
    logic                  mem_valid_reg;
    logic                  mem_rw_reg;
    logic [addr_width-1:0] mem_addr_reg;
    logic [31:0]           mem_dwrite_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_err_reg;
    logic [31:0]           rsp_rdata_reg;
    logic [31:0]           load_data;
    logic [31:0]           merge_data;
    logic                  timed_out;

    assign req_ready      = (state_reg == IDLE);
    assign timed_out      = (timer_reg == TIMEOUT);
    assign mem.mem_valid  = mem_valid_reg;
    assign mem.mem_rw     = mem_rw_reg;
    assign mem.mem_addr   = mem_addr_reg;
    assign mem.mem_dwrite = mem_dwrite_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_err        = rsp_err_reg;
    assign rsp_rdata      = rsp_rdata_reg;

    // Extract/merge works on the live bus data so the result is registered on the completing edge.
    soc_lsu_align u_align (
        .size       (size_reg),
        .sign_ext   (signed_reg),
        .rdata      (mem.mem_dread),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Request FSM, bus drive, ready timer and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            signed_reg     <= 1'b0;
            size_reg       <= SZ_BYTE;
            wdata_reg      <= '0;
            err_pend_reg   <= 1'b0;
            timer_reg      <= '0;
            mem_valid_reg  <= 1'b0;
            mem_rw_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_dwrite_reg <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_rdata_reg  <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg       <= req_we;
                        signed_reg   <= req_signed;
                        size_reg     <= req_size;
                        wdata_reg    <= req_wdata;
                        mem_addr_reg <= req_addr;
                        timer_reg    <= '0;
                        if (req_size == SZ_RSVD) begin
                            // No bus traffic; RESP raises the error one cycle later so the
                            // response lands at the same point as a zero-wait transaction.
                            err_pend_reg <= 1'b1;
                            state_reg    <= RESP;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            mem_valid_reg  <= 1'b1;
                            mem_rw_reg     <= 1'b1;
                            mem_dwrite_reg <= req_wdata;
                            state_reg      <= WR;
                        end else begin
                            mem_valid_reg <= 1'b1;
                            mem_rw_reg    <= 1'b0;
                            state_reg     <= RD;
                        end
                    end
                end
                RD: begin
                    if (mem.mem_ready) begin
                        mem_valid_reg <= 1'b0;
                        if (!we_reg) begin
                            rsp_valid_reg <= 1'b1;
                            rsp_rdata_reg <= load_data;
                            state_reg     <= RESP;
                        end else begin
                            mem_dwrite_reg <= merge_data;
                            state_reg      <= GAP;
                        end
                    end else if (timed_out) begin
                        mem_valid_reg <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_rdata_reg <= '0;
                        state_reg     <= RESP;
                    end else begin
                        timer_reg <= timer_reg + 16'd1;
                    end
                end
                GAP: begin
                    mem_valid_reg <= 1'b1;
                    mem_rw_reg    <= 1'b1;
                    timer_reg     <= '0;
                    state_reg     <= WR;
                end
                WR: begin
                    if (mem.mem_ready) begin
                        mem_valid_reg <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= '0;
                        state_reg     <= RESP;
                    end else if (timed_out) begin
                        mem_valid_reg <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_rdata_reg <= '0;
                        state_reg     <= RESP;
                    end else begin
                        timer_reg <= timer_reg + 16'd1;
                    end
                end
                RESP: begin
                    if (err_pend_reg) begin
                        err_pend_reg  <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_rdata_reg <= '0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    mem_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/soc_mem_lsu.md
Name: soc_mem_lsu

Overview:
- Bus initiator (load/store unit) for the SoC memory bus, driving the byte-addressed, big-endian, unaligned-capable 32-bit responder (block RAM controller).
- Accepts byte/halfword/word load and store requests from the core, with optional sign extension on loads.
- Runs each request as one or two bus transactions; byte and halfword stores use read-modify-write, because the responder always writes 4 bytes.
- Includes a ready timeout that converts a hung responder into an error response.

Parameters:
- addr_width, 8, byte address width; must equal the responder's addr_width.
- timeout_cycles, 255, maximum cycles a bus transaction may wait for mem_ready; range 1..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  high in IDLE; a request is accepted on a cycle with req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  sign-extend a sub-word load.
- req_addr  in  addr_width  byte address; any alignment allowed.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result; 0 for stores and on error.
- rsp_err  out  1  qualifies rsp_valid; reserved size or timeout.
- mem_addr  out  addr_width  bus byte address.
- mem_dwrite  out  32  bus write data; the byte at mem_addr is in bits [31:24].
- mem_dread  in  32  bus read data, same byte order as mem_dwrite.
- mem_rw  out  1  1 = write.
- mem_valid  out  1  bus request.
- mem_ready  in  1  responder completion.

Behaviour:
- Outputs:
  - All outputs except req_ready are registered.
  - req_ready = (state == IDLE), combinational.
  - On reset: state = IDLE; mem_valid, mem_rw, rsp_valid and rsp_err are 0; mem_addr, mem_dwrite, rsp_rdata and the timer are 0.
- Bus contract:
  - mem_addr, mem_dwrite and mem_rw are stable whenever mem_valid is high.
  - A transaction completes on the first posedge where mem_valid && mem_ready.
  - mem_valid then drops for at least one cycle before the next transaction.
  - mem_ready is ignored while mem_valid is low.
- On accept: latch we, size, signed, addr and wdata.
- States:
  - IDLE: on accept with size == 11, go to RESP with err = 1 and issue no bus traffic. Otherwise a load or a sub-word store goes to RD (mem_rw = 0); a word store goes to WR (mem_rw = 1, mem_dwrite = wdata).
  - RD: mem_valid = 1 and mem_addr = latched addr. On mem_ready, capture mem_dread into rbuf.
    - Load: go to RESP.
    - Sub-word store: go to GAP. Merge byte as {wdata[7:0], rbuf[23:0]}; merge half as {wdata[15:0], rbuf[15:0]}.
  - GAP: mem_valid = 0 for exactly one cycle, then go to WR with mem_dwrite = merged data and the same mem_addr.
  - WR: mem_valid = 1 and mem_rw = 1. On mem_ready, go to RESP.
  - RESP: mem_valid = 0 and rsp_valid = 1 for one cycle, then go to IDLE.
- Load result (rsp_rdata):
  - byte: rbuf[31:24], zero- or sign-extended.
  - half: rbuf[31:16], zero- or sign-extended.
  - word: rbuf; req_signed is ignored.
- Latency:
  - Accept at cycle T; mem_valid is first high at T+1.
  - If mem_ready arrives k cycles later (k ≥ 0), a load or word store gives rsp_valid at T+k+2.
  - A sub-word store takes the read latency + 1 (GAP) + the write latency + 1.
- Timeout:
  - A 16-bit timer clears on entry to RD or WR and increments each cycle mem_valid is high without mem_ready.
  - When the timer reaches timeout_cycles: drop mem_valid, go to RESP with err = 1 and rsp_rdata = 0.
  - If mem_ready and timeout occur in the same cycle, mem_ready wins.
  - A read-modify-write that times out on its read issues no write.
- Address wrap: no special handling; addr + 1..3 wraps modulo 2^addr_width inside the responder.
- Reset mid-operation: return to IDLE next cycle, mem_valid = 0, no response issued. A write in flight may or may not have landed.
- New requests are not accepted outside IDLE, including during RESP; back-to-back throughput is one request per (bus latency + 2) cycles minimum.

Decomposition:
- Shared package soc_lsu_pkg holds the size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10) and the state encodings (IDLE, RD, GAP, WR, RESP).
- One combinational sub-module, soc_lsu_align, provides sub-word extract/extend for loads and the merge for stores.
- The FSM and timer stay in soc_mem_lsu.

Test Plan:
- Word store 0x11223344 to 0x10, then word load 0x10 with a 0-wait responder → one write then one read; rsp_rdata = 0x11223344, rsp_valid at T+2 of the load.
- Memory at 0x10..0x13 = 11 22 33 44; byte store 0xAB to 0x11 → bus shows read, one idle gap cycle, then write at 0x11 of 0xAB3344xx with xx = byte 0x14 unchanged; reread of 0x10 = 0x11AB3344.
- Memory 0x20..0x21 = 0x80 0x01: signed half load at 0x20 → 0xFFFF8001; unsigned → 0x00008001; signed byte at 0x21 → 0x00000001.
- Responder with 3 wait states and timeout_cycles = 2 → mem_valid drops after 2 cycles, rsp_err = 1, rsp_rdata = 0; with timeout_cycles = 3 the transaction completes normally.
- req_size = 11 → no mem_valid pulse; rsp_valid && rsp_err exactly 2 cycles after accept.
- Assert reset during the WR of a read-modify-write → mem_valid = 0 next cycle, no rsp_valid, req_ready = 1 the cycle after reset deasserts.
